// File: rtl/zoom_mode_ctrl.sv
// Switch/button conditioning for the zoom datapath: synchronise, debounce, stage the requested
// mode and zoom level, and commit them to the outputs only on a frame boundary.
module zoom_mode_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20,
   parameter int MAX_LEVEL       = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [2:0] sw_in,
   input  logic [1:0] key_n_in,
   input  logic       frame_start,
   output logic       zoom_in_select,
   output logic       zoom_out_select,
   output logic       use_block_avg_select,
   output logic [1:0] zoom_level,
   output logic       mode_changed,
   output logic       pending
);

   // Bits [2:0] are switches (idle 0), bits [4:3] are active-low keys (idle 1).
   localparam logic [4:0]       RST_VAL   = 5'b11000;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [1:0]       LEVEL_MAX = 2'(MAX_LEVEL);

   logic [4:0] w_raw;
   logic [4:0] r_sync1;
   logic [4:0] r_sync2;
   logic [4:0] w_stable;
   logic [1:0] w_press;

   assign w_raw = {key_n_in, sw_in};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= RST_VAL;
         r_sync2 <= RST_VAL;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   generate
      for (genvar gi = 0; gi < 5; gi++) begin : g_deb
         logic [CNT_W-1:0] r_cnt;
         logic             r_stable;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_cnt    <= '0;
               r_stable <= RST_VAL[gi];
            end else if (r_sync2[gi] == r_stable) begin
               r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
               r_stable <= r_sync2[gi];
               r_cnt    <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end

         assign w_stable[gi] = r_stable;

         // A press is the accepted 1->0 transition of a key, seen on the accepting edge.
         if (gi >= 3) begin : g_key
            assign w_press[gi-3] = r_stable & ~r_sync2[gi] & (r_cnt == CNT_LAST);
         end
      end
   endgenerate

   logic       w_req_in;
   logic       w_req_out;
   logic       w_req_avg;
   logic       r_stg_in;
   logic       r_stg_out;
   logic       r_stg_avg;
   logic [1:0] r_stg_level;

   assign w_req_in  = w_stable[0] & ~w_stable[1];
   assign w_req_out = w_stable[1] & ~w_stable[0];
   assign w_req_avg = w_req_out & w_stable[2];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stg_in    <= 1'b0;
         r_stg_out   <= 1'b0;
         r_stg_avg   <= 1'b0;
         r_stg_level <= 2'd0;
      end else begin
         r_stg_in  <= w_req_in;
         r_stg_out <= w_req_out;
         r_stg_avg <= w_req_avg;
         if (w_press[0] && !w_press[1]) begin
            if (r_stg_level != LEVEL_MAX)
               r_stg_level <= r_stg_level + 2'd1;
         end else if (w_press[1] && !w_press[0]) begin
            if (r_stg_level != 2'd0)
               r_stg_level <= r_stg_level - 2'd1;
         end
      end
   end

   assign pending = ({r_stg_in, r_stg_out, r_stg_avg, r_stg_level} !=
                     {zoom_in_select, zoom_out_select, use_block_avg_select, zoom_level});

   // Commit samples the staged registers as they stand before this edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         zoom_in_select       <= 1'b0;
         zoom_out_select      <= 1'b0;
         use_block_avg_select <= 1'b0;
         zoom_level           <= 2'd0;
         mode_changed         <= 1'b0;
      end else begin
         mode_changed <= frame_start & pending;
         if (frame_start && pending) begin
            zoom_in_select       <= r_stg_in;
            zoom_out_select      <= r_stg_out;
            use_block_avg_select <= r_stg_avg;
            zoom_level           <= r_stg_level;
         end
      end
   end

endmodule
